search_ctrl: RTL and testbench
==============================

Name: search_ctrl

Overview:
- Control FSM for the RAM search datapath. It drives the RAM write-enable, the read/write address mux select, the read address counter, the compare-register resets and loads, and the result-address register.
- It runs a linear search over the RAM for the key held in the compare stage. On the first match it stops and stores that match address.
- It sits directly upstream of the RAM, compare, address-register and mux instances, and consumes the compare stage's match flag.

Parameters:
- ADDR_W, 5, RAM address width.
- DEPTH, 32, number of RAM entries searched; must equal 2**ADDR_W.
- RD_LAT, 1, RAM read latency in cycles; must be at least 1.
- CMP_LAT, 1, cycles from cmp_load1 to a valid match; must be at least 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  search request; sampled only in IDLE.
- abort  in  1  cancels a running search.
- wr_en  in  1  external RAM write request.
- match  in  1  compare-stage "found" flag (q4).
- rw  out  1  RAM write enable.
- select4  out  1  mux select: 0 = external write address, 1 = adr_ram2.
- adr_ram2  out  ADDR_W  RAM read address.
- reset1  out  1  compare register 1 clear pulse.
- reset2  out  1  compare register 2 clear pulse.
- select1  out  1  compare register 1 load (RAM data).
- select2  out  1  compare register 2 load (key).
- select3  out  1  result-address register load pulse.
- dataADR  out  ADDR_W  match address presented to the result register.
- busy  out  1  high from CLR through CHECK.
- done  out  1  one-cycle pulse when a search completes.
- hit  out  1  outcome of the last search; held until the next start.
- wr_err  out  1  one-cycle pulse when wr_en arrives while busy.

Behaviour:
- Reset values: all outputs 0, state IDLE, address counter 0.
- Reset is asynchronous and overrides everything, including mid-search.
- States: IDLE, CLR, KEY, ISSUE, WAIT, LOAD, CHECK, FIN.
- IDLE:
  - select4=0 and rw=wr_en, so external writes pass straight through.
  - start=1 moves to CLR and clears hit.
  - If start and wr_en are high together, the write is performed this cycle and the search starts next cycle.
- CLR: reset1=reset2=1 for one cycle; address counter set to 0. Next state KEY.
- KEY: select2=1 for one cycle to load the key. Next state ISSUE.
- ISSUE: adr_ram2 = counter, select4=1. adr_ram2 and select4 stay stable through ISSUE, WAIT, LOAD and CHECK. Next state WAIT.
- WAIT: lasts RD_LAT cycles, then LOAD.
- LOAD: select1=1 for one cycle. Next state CHECK.
- CHECK: lasts CMP_LAT cycles; match is sampled on the last one.
  - match=1: dataADR = counter, select3=1 for one cycle, hit=1, then FIN.
  - match=0 and counter==DEPTH-1: hit=0, then FIN. The last address is detected by compare, never by counter wrap.
  - Otherwise: counter+1, then ISSUE.
- FIN: done=1 for one cycle, busy=0. Next state IDLE. dataADR holds its value until the next hit.
- During busy:
  - rw is forced to 0 and select4 to 1.
  - wr_en=1 is dropped and pulses wr_err the next cycle.
  - start is ignored.
- abort: in any busy state, go to IDLE on the next edge. No done, hit=0, no select3, all pulse outputs 0. abort in IDLE or FIN has no effect.
- Cycle budget with start sampled at edge 0:
  - Per address: 2 + RD_LAT + CMP_LAT cycles (4 with defaults).
  - Hit at address k: done high in cycle 7+4k.
  - Full miss: done high in cycle 131.
- The first match wins: the lowest matching address is reported.

Test Plan:
- Reset mid-search: assert reset in cycle 40 of a search -> every output 0 in the same cycle, no done; a new start afterwards runs normally.
- Hit at address 0: write RAM[0]=3'b101, key 3'b101, pulse start -> one select3 pulse with dataADR=0, hit=1, done in cycle 7.
- Hit at address 9: write RAM[9]=3'b110, all other entries 3'b000, key 3'b110 -> done in cycle 43, dataADR=9, hit=1, exactly one select3 pulse.
- Duplicate keys: RAM[4] and RAM[20] both 3'b011, key 3'b011 -> dataADR=4, search stops at 4, done in cycle 23.
- Full miss: no entry equals key 3'b111 -> adr_ram2 steps 0..31, done in cycle 131, hit=0, select3 never asserted.
- Abort and write collision: wr_en during a search -> rw stays 0 and wr_err pulses; abort in cycle 20 -> IDLE next cycle, done never pulses, external write then succeeds with rw=1 and select4=0.

Source files
------------

// File: rtl/search_ctrl_if.sv
// search_ctrl_if: bus between the search FSM and its environment.
// Master drives requests and match, slave drives RAM/compare controls.
interface search_ctrl_if #(
  parameter int ADDR_W = 5
);
  logic              start;
  logic              abort;
  logic              wr_en;
  logic              match;
  logic              rw;
  logic              select4;
  logic [ADDR_W-1:0] adr_ram2;
  logic              reset1;
  logic              reset2;
  logic              select1;
  logic              select2;
  logic              select3;
  logic [ADDR_W-1:0] dataADR;
  logic              busy;
  logic              done;
  logic              hit;
  logic              wr_err;

  modport master (
    output start, abort, wr_en, match,
    input  rw, select4, adr_ram2,
    input  reset1, reset2, select1,
    input  select2, select3, dataADR,
    input  busy, done, hit, wr_err
  );

  modport slave (
    input  start, abort, wr_en, match,
    output rw, select4, adr_ram2,
    output reset1, reset2, select1,
    output select2, select3, dataADR,
    output busy, done, hit, wr_err
  );
endinterface

// File: rtl/search_ctrl.sv
// search_ctrl: linear RAM search control FSM.
// Walks addresses upward and stops at the first compare match.
module search_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 32,
  parameter int RD_LAT  = 1,
  parameter int CMP_LAT = 1
) (
  input logic          clk,
  input logic          reset,
  search_ctrl_if.slave bus
);
  localparam int LMAX =
    (RD_LAT > CMP_LAT) ? RD_LAT : CMP_LAT;
  localparam int LW =
    (LMAX > 1) ? $clog2(LMAX) : 1;
  localparam logic [LW-1:0] RD_END =
    LW'(RD_LAT - 1);
  localparam logic [LW-1:0] CMP_END =
    LW'(CMP_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_KEY, S_ISSUE,
    S_WAIT, S_LOAD, S_CHECK, S_FIN
  } state_t;

  state_t            st, nxt;
  logic [LW-1:0]     lat_q;
  logic [ADDR_W-1:0] addr_q, dadr_q;
  logic              hit_q, werr_q;
  logic              busy, lat_done;
  logic              rw, sel4, done;
  logic              rst1, rst2;
  logic              sel1, sel2, sel3;

  assign busy = (st != S_IDLE) &&
                (st != S_FIN);
  assign lat_done =
    (st == S_WAIT)  ? (lat_q == RD_END)  :
    (st == S_CHECK) ? (lat_q == CMP_END) :
    1'b0;

  assign bus.rw       = rw;
  assign bus.select4  = sel4;
  assign bus.adr_ram2 = addr_q;
  assign bus.reset1   = rst1;
  assign bus.reset2   = rst2;
  assign bus.select1  = sel1;
  assign bus.select2  = sel2;
  assign bus.select3  = sel3;
  // present the live address while loading
  assign bus.dataADR  = sel3 ? addr_q : dadr_q;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.hit      = hit_q;
  assign bus.wr_err   = werr_q;

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= S_IDLE;
    else       st <= nxt;
  end

  // next state and control decode
  always_comb begin
    nxt  = st;
    rw   = 1'b0;
    sel4 = 1'b0;
    rst1 = 1'b0;
    rst2 = 1'b0;
    sel1 = 1'b0;
    sel2 = 1'b0;
    sel3 = 1'b0;
    done = 1'b0;
    unique case (st)
      S_IDLE: begin
        rw = bus.wr_en && !reset;
        if (bus.start) nxt = S_CLR;
      end
      S_CLR: begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        nxt  = S_KEY;
      end
      S_KEY: begin
        sel2 = 1'b1;
        nxt  = S_ISSUE;
      end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (lat_done) nxt = S_LOAD;
      end
      S_LOAD: begin
        sel1 = 1'b1;
        nxt  = S_CHECK;
      end
      S_CHECK: begin
        if (lat_done) begin
          if (bus.match) begin
            sel3 = 1'b1;
            nxt  = S_FIN;
          end else if (addr_q == LAST) begin
            nxt = S_FIN;
          end else begin
            nxt = S_ISSUE;
          end
        end
      end
      S_FIN: begin
        done = 1'b1;
        nxt  = S_IDLE;
      end
    endcase
    if (busy) begin
      sel4 = 1'b1;
      if (bus.abort) begin
        nxt  = S_IDLE;
        rst1 = 1'b0;
        rst2 = 1'b0;
        sel1 = 1'b0;
        sel2 = 1'b0;
        sel3 = 1'b0;
      end
    end
  end

  // address/latency counters and result state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q  <= '0;
      addr_q <= '0;
      dadr_q <= '0;
      hit_q  <= 1'b0;
      werr_q <= 1'b0;
    end else begin
      werr_q <= busy && bus.wr_en;
      if (st != nxt)
        lat_q <= '0;
      else if (st == S_WAIT ||
               st == S_CHECK)
        lat_q <= lat_q + LW'(1);
      if (st == S_CLR)
        addr_q <= '0;
      else if (st == S_CHECK &&
               nxt == S_ISSUE)
        addr_q <= addr_q + ADDR_W'(1);
      if (st == S_IDLE && bus.start) begin
        hit_q <= 1'b0;
      end else if (sel3) begin
        hit_q  <= 1'b1;
        dadr_q <= addr_q;
      end else if (busy && (bus.abort ||
                   nxt == S_FIN)) begin
        hit_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_search_ctrl.sv
// tb_search_ctrl: directed bench for search_ctrl.
// Models RAM and compare stage around the FSM.
module tb_search_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  search_ctrl_if #(.ADDR_W(5)) bus();

  search_ctrl #(
    .ADDR_W(5), .DEPTH(32),
    .RD_LAT(1), .CMP_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  logic [2:0] ram [32];
  logic [2:0] c1 = '0, c2 = '0;
  logic [2:0] key = '0;
  logic [4:0] waddr = '0;
  logic [2:0] wdata = '0;
  int n_chk = 0, n_pass = 0;
  int n_done = 0;

  assign bus.match = (c1 == c2);

  // RAM writes and compare registers
  always @(posedge clk) begin
    if (bus.rw && !bus.select4)
      ram[waddr] <= wdata;
    if (bus.reset1) c1 <= '0;
    if (bus.reset2) c2 <= '0;
    if (bus.select2) c2 <= key;
    if (bus.select1) c1 <= ram[bus.adr_ram2];
  end

  task automatic check(input string tag,
                       input int got,
                       input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, got, exp);
  endtask

  function automatic int outs();
    return int'({bus.rw, bus.select4,
      bus.adr_ram2, bus.reset1, bus.reset2,
      bus.select1, bus.select2, bus.select3,
      bus.dataADR, bus.busy, bus.done,
      bus.hit, bus.wr_err});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) n_done++;
  endtask

  task automatic wr(input int a, input int d,
                    input bit chk_en);
    waddr = 5'(a);
    wdata = 3'(d);
    bus.wr_en = 1'b1;
    #1;
    if (chk_en) begin
      check("wr_rw", int'(bus.rw), 1);
      check("wr_sel4", int'(bus.select4), 0);
    end
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic search(input string tag,
                        input int k,
                        input int exp_cyc,
                        input int exp_hit,
                        input int exp_adr);
    int n, dcyc, s3, a, aerr;
    key = 3'(k);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 1; dcyc = -1; s3 = 0;
    a = -1; aerr = 0;
    while (dcyc < 0 && n < 300) begin
      if (bus.select3) begin
        s3++;
        a = int'(bus.dataADR);
      end
      if (bus.busy && n >= 3 &&
          int'(bus.adr_ram2) != (n - 3) / 4)
        aerr++;
      if (bus.done) dcyc = n;
      tick();
      n++;
    end
    check({tag, "_done_cyc"}, dcyc, exp_cyc);
    check({tag, "_hit"}, int'(bus.hit), exp_hit);
    check({tag, "_sel3_cnt"}, s3, exp_hit);
    check({tag, "_adr_walk"}, aerr, 0);
    check({tag, "_dataADR"},
          int'(bus.dataADR), exp_adr);
    if (exp_hit != 0)
      check({tag, "_sel3_adr"}, a, exp_adr);
  endtask

  initial begin
    int n, d0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.wr_en = 1'b0;
    #3;
    check("rst_outs", outs(), 0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 32; i++)
      wr(i, (i == 0) ? 5 : 0, i == 0);

    search("hit0", 5, 7, 1, 0);

    wr(0, 0, 1'b0);
    wr(9, 6, 1'b0);
    search("hit9", 6, 43, 1, 9);

    wr(9, 0, 1'b0);
    wr(4, 3, 1'b0);
    wr(20, 3, 1'b0);
    search("dup", 3, 23, 1, 4);

    search("miss", 7, 131, 0, 4);

    key = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d0 = n_done;
    for (n = 1; n < 40; n++) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_outs", outs(), 0);
    check("mid_rst_done", n_done - d0, 0);
    tick();
    reset = 1'b0;
    search("after_rst", 3, 23, 1, 4);

    key = 3'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    d0 = n_done;
    for (n = 1; n < 10; n++) tick();
    waddr = 5'd5;
    wdata = 3'd7;
    bus.wr_en = 1'b1;
    #1;
    check("col_rw", int'(bus.rw), 0);
    check("col_sel4", int'(bus.select4), 1);
    tick();
    bus.wr_en = 1'b0;
    check("col_wr_err", int'(bus.wr_err), 1);
    tick();
    check("col_wr_err_pulse",
          int'(bus.wr_err), 0);
    for (n = 12; n < 20; n++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_sel4", int'(bus.select4), 0);
    check("abort_hit", int'(bus.hit), 0);
    for (n = 0; n < 130; n++) tick();
    check("abort_no_done", n_done - d0, 0);
    check("col_ram5", int'(ram[5]), 0);

    wr(5, 7, 1'b1);
    search("post_abort", 7, 27, 1, 5);

    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end
endmodule
